// File: rtl/hssl_pkg.sv
// Shared constants and types for the HSSL tx path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package hssl_pkg;

    localparam int PACKET_BITS_DEF  = 72;
    localparam int NUM_CHANNELS_DEF = 8;
    localparam int CNT_BITS_DEF     = 32;

    // Receiver synchronisation states reported by the hssl_interface; the link
    // is usable for traffic only in SYNC_ACQUIRED (and with handshake complete).
    typedef enum logic [1:0] {
        SYNC_ACQUIRED = 2'b00,
        RESYNC        = 2'b01,
        LOSS_OF_SYNC  = 2'b10
    } hssl_sync_state_t;

    // Sync part of the link_up_in derivation done beside the hssl_interface.
    function automatic logic sync_ok(input hssl_sync_state_t state);
        return state == SYNC_ACQUIRED;
    endfunction

endpackage

// File: rtl/hssl_tx_slot.sv
// One-entry registered slot holding a packet for a single spiNNlink tx channel.
// Latency: load appears on vld/data one edge later.
// Backpressure: holds vld/data until rdy; free when empty or draining this cycle.
module hssl_tx_slot #(
    parameter int PACKET_BITS = 72
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [PACKET_BITS-1:0] load_data,
    input  logic                   rdy,
    output logic [PACKET_BITS-1:0] data,
    output logic                   vld,
    output logic                   free
);

    // A draining slot can take a new packet on the same edge.
    assign free = !vld || rdy;

    // Load wins over drain; data is held after a drain, only vld drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            data <= load_data;
        end else if (rdy) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/hssl_tx_distributor.sv
// Spreads one packet stream round-robin over NUM_CHANNELS tx slots, gated by link status.
// Latency: 1 cycle from accepted input to slot valid.
// Backpressure: ready when an enabled slot is free; link down drops or stalls per DROP_ON_DOWN.
module hssl_tx_distributor
    import hssl_pkg::*;
#(
    parameter int PACKET_BITS  = PACKET_BITS_DEF,
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int DROP_ON_DOWN = 1,
    parameter int CNT_BITS     = CNT_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_BITS-1:0]  pkt_data_in,
    input  logic                    pkt_vld_in,
    output logic                    pkt_rdy_out,
    output logic [PACKET_BITS-1:0]  txpkt_data_out [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] txpkt_vld_out,
    input  logic [NUM_CHANNELS-1:0] txpkt_rdy_in,
    input  logic                    link_up_in,
    input  logic [NUM_CHANNELS-1:0] chan_en_in,
    input  logic                    clr_cnt_in,
    output logic [CNT_BITS-1:0]     sent_cnt_out,
    output logic [CNT_BITS-1:0]     drop_cnt_out
);

    localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        cand_idx;
    logic                    cand_found;
    logic [PTR_W:0]          scan_sum;
    logic [PTR_W-1:0]        scan_idx;
    logic [NUM_CHANNELS-1:0] slot_free;
    logic [NUM_CHANNELS-1:0] slot_load;
    logic                    xfer;
    logic                    inc_sent;
    logic                    inc_drop;

    // Find the first enabled free slot starting at rr_ptr; scanning from the far
    // end lets the nearest match overwrite the others.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (scan_sum >= (PTR_W + 1)'(NUM_CHANNELS)) begin
                scan_sum = scan_sum - (PTR_W + 1)'(NUM_CHANNELS);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (chan_en_in[scan_idx] && slot_free[scan_idx]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    assign pkt_rdy_out = link_up_in ? cand_found : (DROP_ON_DOWN != 0);
    assign xfer        = pkt_vld_in && pkt_rdy_out;
    assign inc_sent    = xfer && link_up_in;
    assign inc_drop    = xfer && !link_up_in;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_slot
        assign slot_load[i] = inc_sent && (cand_idx == PTR_W'(i));

        hssl_tx_slot #(
            .PACKET_BITS (PACKET_BITS)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (slot_load[i]),
            .load_data (pkt_data_in),
            .rdy       (txpkt_rdy_in[i]),
            .data      (txpkt_data_out[i]),
            .vld       (txpkt_vld_out[i]),
            .free      (slot_free[i])
        );
    end

    // Advance the round-robin pointer past the slot just loaded; drops leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (inc_sent) begin
            rr_ptr <= (cand_idx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : cand_idx + 1'b1;
        end
    end

    // Saturating statistics; a clear beats an increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_cnt_out <= '0;
            drop_cnt_out <= '0;
        end else if (clr_cnt_in) begin
            sent_cnt_out <= '0;
            drop_cnt_out <= '0;
        end else begin
            if (inc_sent && (sent_cnt_out != '1)) begin
                sent_cnt_out <= sent_cnt_out + 1'b1;
            end
            if (inc_drop && (drop_cnt_out != '1)) begin
                drop_cnt_out <= drop_cnt_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hssl_tx_distributor.sv
// Bench for hssl_tx_distributor: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hssl_tx_distributor;

    localparam int N    = 8;
    localparam int CB   = 5;
    localparam int MAXC = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_rdy, pkt_rdy_bp;
    logic [71:0] tx_data [N];
    logic [71:0] tx_data_bp [N];
    logic [7:0]  tx_vld, tx_vld_bp;
    logic [7:0]  tx_rdy;
    logic        link_up;
    logic [7:0]  chan_en;
    logic        clr_cnt;
    logic [CB-1:0] sent_cnt, drop_cnt, sent_cnt_bp, drop_cnt_bp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_vld;
    logic [71:0] m_dat [N];
    int          m_rr, m_sent, m_drop;

    always #5 clk = ~clk;

    hssl_tx_distributor #(
        .PACKET_BITS(72), .NUM_CHANNELS(N), .DROP_ON_DOWN(1), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .pkt_data_in(pkt_data), .pkt_vld_in(pkt_vld),
        .pkt_rdy_out(pkt_rdy), .txpkt_data_out(tx_data), .txpkt_vld_out(tx_vld),
        .txpkt_rdy_in(tx_rdy), .link_up_in(link_up), .chan_en_in(chan_en),
        .clr_cnt_in(clr_cnt), .sent_cnt_out(sent_cnt), .drop_cnt_out(drop_cnt)
    );

    hssl_tx_distributor #(
        .PACKET_BITS(72), .NUM_CHANNELS(N), .DROP_ON_DOWN(0), .CNT_BITS(CB)
    ) dut_bp (
        .clk(clk), .reset(reset), .pkt_data_in(pkt_data), .pkt_vld_in(pkt_vld),
        .pkt_rdy_out(pkt_rdy_bp), .txpkt_data_out(tx_data_bp), .txpkt_vld_out(tx_vld_bp),
        .txpkt_rdy_in(tx_rdy), .link_up_in(link_up), .chan_en_in(chan_en),
        .clr_cnt_in(clr_cnt), .sent_cnt_out(sent_cnt_bp), .drop_cnt_out(drop_cnt_bp)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // First enabled slot that is empty or draining, scanning from the rr pointer.
    function automatic int model_cand();
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (chan_en[idx[2:0]] && (!m_vld[idx[2:0]] || tx_rdy[idx[2:0]])) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = '0;
        for (int i = 0; i < N; i++) m_dat[i] = '0;
        m_rr = 0; m_sent = 0; m_drop = 0;
    endtask

    // One clock: check ready against the model, advance the model, check outputs.
    task automatic cycle();
        int          c;
        logic        exp_rdy;
        logic [7:0]  nv;
        logic [71:0] nd [N];
        int          nrr, ns, ndp;
        #1;
        c = model_cand();
        exp_rdy = link_up ? (c >= 0) : 1'b1;
        chk("pkt_rdy", 128'(pkt_rdy), 128'(exp_rdy));
        chk("pkt_rdy_bp", 128'(pkt_rdy_bp), 128'(link_up ? (c >= 0) : 1'b0));
        nv = m_vld & ~tx_rdy;
        for (int i = 0; i < N; i++) nd[i] = m_dat[i];
        nrr = m_rr; ns = m_sent; ndp = m_drop;
        if (pkt_vld && exp_rdy && link_up) begin
            nv[c[2:0]] = 1'b1;
            nd[c] = pkt_data;
            nrr = (c + 1) % N;
            ns = sat(ns + 1);
        end else if (pkt_vld && exp_rdy) begin
            ndp = sat(ndp + 1);
        end
        if (clr_cnt) begin
            ns = 0; ndp = 0;
        end
        @(posedge clk);
        m_vld = nv;
        for (int i = 0; i < N; i++) m_dat[i] = nd[i];
        m_rr = nrr; m_sent = ns; m_drop = ndp;
        #1;
        chk("tx_vld", 128'(tx_vld), 128'(m_vld));
        chk("tx_vld_bp", 128'(tx_vld_bp), 128'(m_vld));
        for (int i = 0; i < N; i++) chk($sformatf("tx_data%0d", i), 128'(tx_data[i]), 128'(m_dat[i]));
        chk("sent_cnt", 128'(sent_cnt), 128'(m_sent));
        chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
        chk("sent_cnt_bp", 128'(sent_cnt_bp), 128'(m_sent));
        chk("drop_cnt_bp", 128'(drop_cnt_bp), 128'(0));
    endtask

    task automatic drive(input logic lu, input logic [7:0] en, input logic [7:0] rdy,
                         input logic v, input logic [71:0] d, input logic clr);
        link_up = lu; chan_en = en; tx_rdy = rdy; pkt_vld = v; pkt_data = d; clr_cnt = clr;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 72'h0, 1'b0);
        model_reset();
        #12;
        chk("rst_vld", 128'(tx_vld), 128'(0));
        for (int i = 0; i < N; i++) chk($sformatf("rst_data%0d", i), 128'(tx_data[i]), 128'(0));
        chk("rst_sent", 128'(sent_cnt), 128'(0));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // 1: back-to-back packets spread over all channels in order
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 8'hff, 8'hff, 1'b1, 72'(k), 1'b0);
            cycle();
            chk("t1_vld", 128'(tx_vld[k[2:0]]), 128'(1));
            chk("t1_data", 128'(tx_data[k[2:0]]), 128'(k));
        end
        chk("t1_sent", 128'(sent_cnt), 128'(16));

        // 2: sparse enable mask, stall, then reuse of a draining slot
        drive(1'b1, 8'hff, 8'hff, 1'b0, 72'h0, 1'b0);
        cycle();
        drive(1'b1, 8'b0000_0101, 8'h00, 1'b1, 72'hA1, 1'b0);
        cycle();
        drive(1'b1, 8'b0000_0101, 8'h00, 1'b1, 72'hB2, 1'b0);
        cycle();
        chk("t2_ch0", 128'(tx_data[0]), 128'h0A1);
        chk("t2_ch2", 128'(tx_data[2]), 128'h0B2);
        drive(1'b1, 8'b0000_0101, 8'h00, 1'b1, 72'hC3, 1'b0);
        #1 chk("t2_stall", 128'(pkt_rdy), 128'(0));
        cycle();
        drive(1'b1, 8'b0000_0101, 8'b0000_0100, 1'b1, 72'hC3, 1'b0);
        cycle();
        chk("t2_reuse_vld", 128'(tx_vld), 128'h05);
        chk("t2_reuse_data", 128'(tx_data[2]), 128'h0C3);

        // 3: link down drops without loading any slot
        drive(1'b1, 8'hff, 8'hff, 1'b0, 72'h0, 1'b0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 8'hff, 8'h00, 1'b1, 72'(100 + k), 1'b0);
            cycle();
        end
        chk("t3_vld", 128'(tx_vld), 128'(0));
        chk("t3_drop", 128'(drop_cnt), 128'(5));
        chk("t3_bp_drop", 128'(drop_cnt_bp), 128'(0));

        // 4: loaded slot stays stable across link down and disable
        drive(1'b1, 8'hff, 8'h00, 1'b1, 72'hD4D4, 1'b0);
        cycle();
        chk("t4_load", 128'(tx_vld), 128'h08);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'hf7, 8'h00, 1'b0, 72'h0, 1'b0);
            cycle();
            chk("t4_hold_vld", 128'(tx_vld[3]), 128'(1));
            chk("t4_hold_data", 128'(tx_data[3]), 128'hD4D4);
        end
        drive(1'b0, 8'hf7, 8'h08, 1'b0, 72'h0, 1'b0);
        cycle();
        chk("t4_drain", 128'(tx_vld[3]), 128'(0));

        // 5: saturation of drop counter, clear wins over increment
        drive(1'b0, 8'hff, 8'hff, 1'b0, 72'h0, 1'b1);
        cycle();
        for (int k = 0; k < 30; k++) begin
            drive(1'b0, 8'hff, 8'hff, 1'b1, 72'(k), 1'b0);
            cycle();
        end
        chk("t5_30", 128'(drop_cnt), 128'(30));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'hff, 8'hff, 1'b1, 72'(k), 1'b0);
            cycle();
        end
        chk("t5_sat", 128'(drop_cnt), 128'h1f);
        drive(1'b0, 8'hff, 8'hff, 1'b1, 72'h0, 1'b1);
        cycle();
        chk("t5_clr", 128'(drop_cnt), 128'(0));

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0,
                  (($urandom % 3) == 0) ? 8'hff : 8'($urandom),
                  8'($urandom),
                  ($urandom % 4) != 0,
                  72'({$urandom, $urandom, $urandom}),
                  ($urandom % 64) == 0);
            cycle();
        end

        // 6: asynchronous reset with full slots, rr restarts at channel 0
        for (int k = 0; k < N; k++) begin
            drive(1'b1, 8'hff, 8'h00, 1'b1, 72'(200 + k), 1'b0);
            cycle();
        end
        chk("t6_full", 128'(tx_vld), 128'hff);
        drive(1'b1, 8'hff, 8'h00, 1'b0, 72'h0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_vld", 128'(tx_vld), 128'(0));
        chk("t6_async_sent", 128'(sent_cnt), 128'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'hff, 8'hff, 1'b1, 72'hE6, 1'b0);
        cycle();
        chk("t6_ch0_vld", 128'(tx_vld), 128'h01);
        chk("t6_ch0_data", 128'(tx_data[0]), 128'h0E6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
